// File: rtl/gouram_trace_serialiser.sv
// gouram_trace_serialiser: buffers 129-bit gouram trace records in a FIFO and streams
// each record as four 32-bit beats, least-significant first, counting records lost to overflow.
module gouram_trace_serialiser #(
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [128:0]           trace_i,
   output logic [31:0]            m_data,
   output logic                   m_valid,
   output logic                   m_last,
   input  logic                   m_ready,
   input  logic                   overflow_clr,
   output logic [CNT_WIDTH-1:0]   overflow_count,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, SEND} state_t;
   state_t        state;
   logic [127:0]  mem [DEPTH];
   logic [127:0]  rec;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    beat, beat_nxt;
   logic          empty, full, xfer, pop, push, drop;
   always_comb begin
      empty    = fifo_level == '0;
      full     = fifo_level == (AW+1)'(DEPTH);
      xfer     = m_valid && m_ready;
      beat_nxt = beat + 2'd1;
      // head is popped either to start from idle or straight after a final beat, so records run back to back
      pop      = !empty && (state == IDLE || (xfer && beat == 2'd3));
      push     = trace_i[128] && (!full || pop);
      drop     = trace_i[128] && !push;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= trace_i[127:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         overflow_count <= '0;
      end else begin
         wr_ptr         <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr         <= pop ? rd_ptr + AW'(1) : rd_ptr;
         fifo_level     <= push == pop ? fifo_level :
                           push ? fifo_level + (AW+1)'(1) : fifo_level - (AW+1)'(1);
         overflow_count <= overflow_clr ? CNT_WIDTH'(drop) :
                           (drop && !(&overflow_count)) ? overflow_count + CNT_WIDTH'(1) : overflow_count;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         beat    <= '0;
         rec     <= '0;
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (pop) begin
         state   <= SEND;
         beat    <= '0;
         rec     <= mem[rd_ptr];
         m_data  <= mem[rd_ptr][31:0];
         m_valid <= 1'b1;
         m_last  <= 1'b0;
      end else if (xfer && beat == 2'd3) begin
         state   <= IDLE;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (xfer) begin
         beat    <= beat_nxt;
         m_data  <= rec[{beat_nxt, 5'd0} +: 32];
         m_last  <= beat_nxt == 2'd3;
      end
endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// tb_gouram_trace_serialiser: directed checks of latency, back-pressure, overflow, counter and reset behaviour.
module tb_gouram_trace_serialiser;
   logic         clk = 1'b0, rst_n = 1'b0, m_ready = 1'b0, overflow_clr = 1'b0;
   logic [128:0] trace_i = '0;
   logic [31:0]  m_data;
   logic         m_valid, m_last;
   logic [15:0]  overflow_count;
   logic [3:0]   fifo_level;
   int           n_checks = 0, n_fail = 0;

   gouram_trace_serialiser #(.DEPTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .trace_i(trace_i), .m_data(m_data), .m_valid(m_valid),
      .m_last(m_last), .m_ready(m_ready), .overflow_clr(overflow_clr),
      .overflow_count(overflow_count), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   // beat b of record n is {n, b, C0DE}, so every beat names its record and position
   function automatic logic [31:0] bv(int n, int b);
      return {n[7:0], b[7:0], 16'hC0DE};
   endfunction

   function automatic logic [128:0] strobe(int n);
      return {1'b1, bv(n, 3), bv(n, 2), bv(n, 1), bv(n, 0)};
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", m_last); end
      n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
      n_checks++; if (overflow_count !== 16'h0) begin n_fail++; $display("FAIL reset_ovf: got %h want 0", overflow_count); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      @(negedge clk);
      m_ready = 1'b1;
      trace_i = {1'b1, 128'h44444444_33333333_22222222_11111111};
      @(negedge clk);
      trace_i = '0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: valid=%b want 0", m_valid); end
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== exp[b] || m_last !== (b == 3)) begin
            n_fail++;
            $display("FAIL single_beat%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                     b, m_valid, m_data, m_last, exp[b], b == 3);
         end
      end
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: valid=%b want 0", m_valid); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      int pat [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
      int idx = 0;
      @(negedge clk);
      m_ready = 1'b0;
      trace_i = {1'b1, 128'h44444444_33333333_22222222_11111111};
      @(negedge clk);
      trace_i = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== exp[idx] || m_last !== (idx == 3)) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                     i, m_valid, m_data, m_last, exp[idx], idx == 3);
         end
         m_ready = pat[i] != 0;
         if (pat[i] != 0) idx++;
      end
      @(negedge clk);
      m_ready = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: valid=%b want 0 after 4 transfers", m_valid); end
   endtask

   task automatic test_overflow;
      m_ready = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         trace_i = strobe(n);
      end
      @(negedge clk);
      trace_i = '0;
      n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
      n_checks++; if (overflow_count !== 16'd2) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", overflow_count); end
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== bv(1, 0)) begin
         n_fail++;
         $display("FAIL ovf_head: valid=%b data=%h want valid=1 data=%h", m_valid, m_data, bv(1, 0));
      end
   endtask

   task automatic test_push_at_pop;
      for (int b = 0; b < 4; b++) begin
         if (b != 0) @(negedge clk);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== bv(1, b) || m_last !== (b == 3)) begin
            n_fail++;
            $display("FAIL pap_beat%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                     b, m_valid, m_data, m_last, bv(1, b), b == 3);
         end
         m_ready = 1'b1;
         if (b == 3) trace_i = strobe(12);
      end
      @(negedge clk);
      trace_i = '0;
      n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL pap_level: got %0d want 8", fifo_level); end
      n_checks++; if (overflow_count !== 16'd2) begin n_fail++; $display("FAIL pap_count: got %0d want 2", overflow_count); end
   endtask

   task automatic test_drain;
      int ids [9] = '{2, 3, 4, 5, 6, 7, 8, 9, 12};
      for (int r = 0; r < 9; r++)
         for (int b = 0; b < 4; b++) begin
            if (r != 0 || b != 0) @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== bv(ids[r], b) || m_last !== (b == 3)) begin
               n_fail++;
               $display("FAIL drain_r%0d_b%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                        r, b, m_valid, m_data, m_last, bv(ids[r], b), b == 3);
            end
         end
      @(negedge clk);
      m_ready = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: valid=%b want 0", m_valid); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_counter;
      m_ready = 1'b0;
      @(negedge clk);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      n_checks++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d want 0", overflow_count); end
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         trace_i = strobe(40 + n);
      end
      @(negedge clk);
      trace_i = strobe(52);
      overflow_clr = 1'b1;
      @(negedge clk);
      trace_i = '0;
      overflow_clr = 1'b0;
      n_checks++; if (overflow_count !== 16'd1) begin n_fail++; $display("FAIL cnt_clr_drop: got %0d want 1", overflow_count); end
      @(negedge clk);
      overflow_clr = 1'b1;
      trace_i = strobe(60);
      @(negedge clk);
      overflow_clr = 1'b0;
      repeat (65533) @(negedge clk);
      n_checks++; if (overflow_count !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_near_sat: got %h want fffe", overflow_count); end
      repeat (5) @(negedge clk);
      trace_i = '0;
      n_checks++; if (overflow_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", overflow_count); end
      n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL cnt_level: got %0d want 8", fifo_level); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_ready = 1'b0;
      for (int n = 20; n <= 23; n++) begin
         @(negedge clk);
         trace_i = strobe(n);
      end
      @(negedge clk);
      trace_i = '0;
      m_ready = 1'b1;
      n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL rm_level: got %0d want 3", fifo_level); end
      repeat (2) @(negedge clk);
      m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== bv(20, 2)) begin
         n_fail++;
         $display("FAIL rm_beat2: valid=%b data=%h want valid=1 data=%h", m_valid, m_data, bv(20, 2));
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", m_valid); end
      n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", m_data); end
      n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rm_last: got %b want 0", m_last); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rm_level0: got %0d want 0", fifo_level); end
      @(negedge clk);
      rst_n = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      trace_i = strobe(30);
      @(negedge clk);
      trace_i = '0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale: valid=%b data=%h want valid=0", m_valid, m_data); end
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== bv(30, b) || m_last !== (b == 3)) begin
            n_fail++;
            $display("FAIL rm_new_b%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                     b, m_valid, m_data, m_last, bv(30, b), b == 3);
         end
      end
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_end: valid=%b data=%h want valid=0", m_valid, m_data); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rm_end_level: got %0d want 0", fifo_level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_push_at_pop();
      test_drain();
      test_counter();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gouram_trace_serialiser.md
# gouram_trace_serialiser

Downstream drain for the gouram trace unit. It captures each 129-bit trace record from `trace_data_o` into a small FIFO and emits every record as four 32-bit beats on a valid/ready stream toward off-chip trace storage or a debug link. It absorbs bursts from the tracer and counts any records lost to overflow.

## Interface

Parameters:
- `DEPTH`, default 8: FIFO depth in records; a power of two, ≥ 2.
- `CNT_WIDTH`, default 16: width of the dropped-record counter.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `trace_i`, in, 129: trace record from gouram. Bit 128 is the record-valid strobe, held high for exactly one cycle per new record. Bits [127:0] are the payload.
- `m_data`, out, 32: current beat.
- `m_valid`, out, 1: beat valid.
- `m_last`, out, 1: high on the final (4th) beat of a record.
- `m_ready`, in, 1: sink accepts the beat.
- `overflow_clr`, in, 1: synchronous clear of `overflow_count`.
- `overflow_count`, out, CNT_WIDTH: number of records dropped; saturates at all-ones.
- `fifo_level`, out, $clog2(DEPTH)+1: number of records currently in the FIFO (0..DEPTH).

## Operation

- **Push.** A push is attempted when `trace_i[128]`=1 at a clock edge. The payload [127:0] is written at the tail.
  - The push is accepted if `fifo_level` < DEPTH, or if a pop occurs on the same edge.
  - Otherwise the record is dropped and `overflow_count` increments, saturating.
- **Overflow clear.** `overflow_clr`=1 sets `overflow_count` to 0. If a drop occurs on the same edge, the count becomes 1.
- **Serialiser FSM, state IDLE.**
  - `m_valid`=0.
  - If `fifo_level`>0, pop the head into a 128-bit output register, set beat index to 0, and go to SEND.
- **Serialiser FSM, state SEND.**
  - `m_valid`=1.
  - `m_data` = record[32·beat+31 : 32·beat], least-significant beat first: beat 0 = [31:0], beat 3 = [127:96].
  - `m_last` = (beat==3).
  - A transfer occurs when `m_valid` & `m_ready` are both high.
  - On a transfer with beat<3: beat increments.
  - On a transfer with beat==3:
    - If the FIFO is non-empty, pop the next record, set beat to 0, and stay in SEND (records go back to back with no bubble).
    - Otherwise go to IDLE.
- **Stability.** While `m_valid`=1 and `m_ready`=0, `m_data`, `m_last` and the beat index must hold stable.
- **Pointers.** Read and write pointers wrap modulo DEPTH.
- **Simultaneous push and pop.** On the same edge, `fifo_level` is unchanged.
- **Ordering.** Records must never be reordered, duplicated or partially emitted, except on reset.

## Timing

- **Reset values (asynchronous):**
  - FSM = IDLE; beat = 0; FIFO empty, pointers 0.
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `overflow_count`=0, `fifo_level`=0.
- **Reset mid-operation.** An in-flight record and all FIFO contents are discarded. The first record sampled after deassertion is the next to be emitted.
- **`fifo_level`.** Registered; it reflects pushes and pops of the previous edge.
- **Latency, FIFO empty and FSM IDLE.**
  - Record strobe sampled at edge E0 → written at E0.
  - Popped at E1 → `m_valid`=1 with beat 0 from just after E1.
  - First beat therefore appears 2 cycles after the record was presented on `trace_i`.
- **Throughput.** One beat per cycle with `m_ready` held high, i.e. one record per 4 cycles. The FIFO fills if gouram emits records faster than that.
- **Full FIFO.** A record presented with `fifo_level`=DEPTH and no pop that cycle is dropped. A record presented on the same edge as a pop (final-beat transfer or IDLE load) is accepted.
- **Beat handshake.** `m_ready` may toggle arbitrarily. Each beat transfers exactly once.

## Test plan

1. **Single record.**
   - Stimulus: after reset, one strobe with payload 0x44444444_33333333_22222222_11111111; `m_ready`=1.
   - Required: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles starting 2 cycles after the strobe; `m_last` only on 0x44444444; then `m_valid`=0.
2. **Back-pressure.**
   - Stimulus: same record; `m_ready` toggles 0,1,0,0,1,1,0,1.
   - Required: each beat held stable while `m_ready`=0; exactly 4 transfers, in order.
3. **Overflow.**
   - Stimulus: DEPTH=8, `m_ready`=0, 11 strobes on consecutive cycles.
   - Required: 1 record loaded into the output register and 8 in the FIFO; `fifo_level`=8; `overflow_count`=2.
   - Then: `m_ready`=1 drains 9 records with no gap between records; `fifo_level` returns to 0.
4. **Push at pop edge.**
   - Stimulus: FIFO full; strobe on the same edge as a final-beat transfer.
   - Required: record accepted, `overflow_count` unchanged, `fifo_level` stays 8.
5. **Counter controls.**
   - Stimulus: `overflow_clr` coincident with a drop.
   - Required: `overflow_count`=1.
   - Stimulus: force 2^CNT_WIDTH+3 drops.
   - Required: count saturates at 0xFFFF.
6. **Reset mid-record.**
   - Stimulus: assert `rst_n`=0 during beat 2 of a record, with 3 records queued.
   - Required: outputs zero immediately; after release, only newly strobed records are emitted.
